fetch_controller: RTL
=====================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter TRAP_VECTOR, default 32'h0000_0080: fetch address on misaligned redirect (FETCH_TRAP_EN only).
REQ-003 Port clock  in  1  single clock; all state updates on rising edge.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Port imem_req  out  1  instruction memory request.
REQ-006 Port imem_addr  out  32  request address, equal to pc while imem_req=1.
REQ-007 Port imem_ready  in  1  memory completes the request this cycle; imem_rdata valid.
REQ-008 Port imem_rdata  in  32  instruction word.
REQ-009 Port instr_valid  out  1  instr/instr_pc hold a fetched instruction.
REQ-010 Port instr  out  32  fetched instruction word.
REQ-011 Port instr_pc  out  32  address of instr.
REQ-012 Port instr_accept  in  1  downstream consumes instr when instr_valid=1.
REQ-013 Port redirect_valid  in  1  branch/jump redirect request.
REQ-014 Port redirect_pc  in  32  redirect target.
REQ-015 Port halt  in  1  level; stop issuing fetches.
REQ-016 Port pc  out  32  next fetch address.
REQ-017 Port trap  out  1  one-cycle misaligned-redirect pulse.

Function
REQ-018 States: FETCH, HOLD, HALTED; encoding free.
REQ-019 FETCH, halt=0: imem_req=1, imem_addr=pc; imem_ready=0 -> stay, pc unchanged.
REQ-020 FETCH, imem_ready=1: next cycle instr=imem_rdata, instr_pc=pc, instr_valid=1, pc=pc+4, state HOLD.
REQ-021 pc+4 wraps modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-022 HOLD: imem_req=0; instr, instr_pc, instr_valid stable until instr_accept=1.
REQ-023 HOLD, instr_accept=1: next cycle instr_valid=0, state FETCH (HALTED if halt=1).
REQ-024 FETCH, halt=1: imem_req=0 this cycle, no ready sampled, next state HALTED.
REQ-025 HALTED: imem_req=0; halt=0 -> FETCH next cycle.
REQ-026 redirect_valid=1 overrides all other events in every state: next cycle pc=redirect_pc, instr_valid=0, state FETCH (HALTED if halt=1).
REQ-027 Redirect coincident with imem_ready=1: returned word discarded, never presented.
REQ-028 Redirect coincident with instr_accept=1: accept consumed, instruction dropped, no other effect.
REQ-029 Memory contract: imem_addr may change while imem_req=1 only after redirect; memory samples address only with imem_ready.
REQ-030 Throughput: at most one instruction per two cycles; minimum fetch latency one cycle from imem_ready to instr_valid.

Reset
REQ-031 reset=1 at clock edge: state FETCH, pc=RESET_VECTOR, instr_valid=0, instr=0, instr_pc=0, trap=0.
REQ-032 imem_req=0 during any cycle with reset=1; first request in cycle after reset deasserts.
REQ-033 reset overrides redirect, halt, accept, and any outstanding request; pending data discarded.

Configuration
REQ-034 Macro FETCH_TRAP_EN defined: redirect with redirect_pc[1:0]!=0 -> pc=TRAP_VECTOR, trap=1 for exactly the next cycle, state FETCH.
REQ-035 FETCH_TRAP_EN undefined: redirect loads {redirect_pc[31:2],2'b00}; trap tied 0; TRAP_VECTOR unused.

Verification
REQ-036 Reset, halt=0, imem_ready=1 always, instr_accept=1 always -> imem_addr 0,4,8,...; instr_pc matches; instr_valid alternates.
REQ-037 imem_ready delayed 3 cycles at addr 8 -> imem_addr held 8 for 4 cycles, instr_pc=8 presented once.
REQ-038 instr_accept low 5 cycles in HOLD -> instr/instr_pc stable, imem_req=0 throughout.
REQ-039 redirect_pc=32'h100 with imem_ready=1 same cycle -> returned word dropped, next imem_addr=32'h100.
REQ-040 halt=1 in FETCH for 4 cycles -> imem_req=0 in those cycles, fetch resumes at unchanged pc after halt=0.
REQ-041 redirect_pc=32'h102: FETCH_TRAP_EN -> trap pulse, next imem_addr=32'h80; undefined -> imem_addr=32'h100, trap=0.

Source files
------------

// File: rtl/fetch_controller.sv
// fetch_controller
//   Instruction fetch sequencer. It issues one memory request at a time from
//   pc, captures the returned word, and presents it downstream until it is
//   accepted. It then moves on to pc+4. Redirects and halts can interrupt
//   this flow at any point.
//
// Parameters
//   RESET_VECTOR   first fetch address after reset
//   TRAP_VECTOR    fetch address after a misaligned redirect (FETCH_TRAP_EN)
//
// Ports
//   clock          rising-edge clock
//   reset          synchronous, active-high reset
//   imem_req       instruction memory request
//   imem_addr      request address (equals pc)
//   imem_ready     memory completes the request, imem_rdata valid
//   imem_rdata     returned instruction word
//   instr_valid    instr/instr_pc hold a fetched instruction
//   instr          fetched instruction word
//   instr_pc       address of instr
//   instr_accept   downstream consumes instr when instr_valid=1
//   redirect_valid branch/jump redirect request (highest priority)
//   redirect_pc    redirect target
//   halt           level; stop issuing fetches
//   pc             next fetch address
//   trap           one-cycle pulse after a misaligned redirect
//
// Configuration
//   FETCH_TRAP_EN  when defined, a redirect to a misaligned target fetches
//                  from TRAP_VECTOR and pulses trap. When undefined, the low
//                  two bits of the target are cleared and trap stays 0.

module fetch_controller #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_accept,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] pc,
  output logic        trap
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_HOLD   = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc_next;
  logic [31:0] instr_next;
  logic [31:0] instr_pc_next;
  logic        instr_valid_next;
  logic        trap_next;

  // A request is only visible while fetching and not halted. Reset masks it
  // combinationally so that no request leaks out during the reset cycle.
  assign imem_req  = (state == S_FETCH) && !halt && !reset;
  assign imem_addr = pc;

`ifndef FETCH_TRAP_EN
  logic unused_bits;
  assign unused_bits = ^{TRAP_VECTOR, redirect_pc[1:0]};
`endif

  // Redirect wins over every other event. A word returned in the same cycle
  // as a redirect is dropped, and an accept in the same cycle has no effect
  // beyond the drop.
  always_comb begin
    state_next       = state;
    pc_next          = pc;
    instr_next       = instr;
    instr_pc_next    = instr_pc;
    instr_valid_next = instr_valid;
    trap_next        = 1'b0;

    if (redirect_valid) begin
      instr_valid_next = 1'b0;
`ifdef FETCH_TRAP_EN
      if (redirect_pc[1:0] != 2'b00) begin
        pc_next    = TRAP_VECTOR;
        trap_next  = 1'b1;
        state_next = S_FETCH;
      end else begin
        pc_next    = redirect_pc;
        state_next = halt ? S_HALTED : S_FETCH;
      end
`else
      pc_next    = {redirect_pc[31:2], 2'b00};
      state_next = halt ? S_HALTED : S_FETCH;
`endif
    end else begin
      case (state)
        S_FETCH: begin
          if (halt) begin
            state_next = S_HALTED;
          end else if (imem_ready) begin
            instr_next       = imem_rdata;
            instr_pc_next    = pc;
            instr_valid_next = 1'b1;
            pc_next          = pc + 32'd4;
            state_next       = S_HOLD;
          end
        end
        S_HOLD: begin
          if (instr_accept) begin
            instr_valid_next = 1'b0;
            state_next       = halt ? S_HALTED : S_FETCH;
          end
        end
        S_HALTED: begin
          if (!halt) begin
            state_next = S_FETCH;
          end
        end
        default: begin
          state_next = S_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_FETCH;
      pc          <= RESET_VECTOR;
      instr       <= 32'h0;
      instr_pc    <= 32'h0;
      instr_valid <= 1'b0;
      trap        <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      instr       <= instr_next;
      instr_pc    <= instr_pc_next;
      instr_valid <= instr_valid_next;
      trap        <= trap_next;
    end
  end

endmodule
